// File: rtl/risc_v_pipeline_pkg.sv
// Shared definitions for the RV32I/RV64I decode stage.
//   - Major-opcode constants for the base integer ISA.
//   - fmt_e: instruction format classification.
//   - decode_bundle_t: fixed-width decoded fields that travel through the
//     stage's output and skid registers. The XLEN-wide pc and immediate
//     travel beside the bundle in the top, because a package type cannot
//     follow a module parameter.
//   - opcode_to_fmt: opcode -> format classification.
package risc_v_pipeline_pkg;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_S     = 7'b0100011;
    localparam logic [6:0] OPC_B     = 7'b1100011;
    localparam logic [6:0] OPC_J     = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    // Register-index width as encoded in the instruction word.
    localparam int unsigned INST_REG_W = 5;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_UNK = 3'd6
    } fmt_e;

    typedef struct packed {
        logic [6:0]            opcode;
        logic [INST_REG_W-1:0] rd;
        logic [INST_REG_W-1:0] rs1;
        logic [INST_REG_W-1:0] rs2;
        logic [2:0]            funct3;
        logic [6:0]            funct7;
        fmt_e                  fmt;
        logic                  rd_we;
        logic                  rs1_use;
        logic                  rs2_use;
        logic                  illegal;
    } decode_bundle_t;

    function automatic fmt_e opcode_to_fmt(input logic [6:0] opcode);
        fmt_e f;
        unique case (opcode)
            OPC_R:                      f = FMT_R;
            OPC_I, OPC_LOAD, OPC_JALR:  f = FMT_I;
            OPC_S:                      f = FMT_S;
            OPC_B:                      f = FMT_B;
            OPC_LUI, OPC_AUIPC:         f = FMT_U;
            OPC_J:                      f = FMT_J;
            default:                    f = FMT_UNK;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// Combinational immediate generator.
//   inst_i [31:7]  instruction bits that carry immediates (opcode not needed)
//   fmt_i          decoded format
//   imm_o  XLEN    immediate, sign bit inst[31] extended to XLEN; 0 for R/UNK
module decode_imm_gen
    import risc_v_pipeline_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:7]     inst_i,
    input  fmt_e            fmt_i,
    output logic [XLEN-1:0] imm_o
);

    // Every format's immediate fits in 32 signed bits; build that first and
    // widen once, so XLEN=32 and XLEN=64 share one expression set.
    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        unique case (fmt_i)
            FMT_I: imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            FMT_S: imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            FMT_B: imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                            inst_i[30:25], inst_i[11:8], 1'b0};
            FMT_U: imm32 = {inst_i[31:12], 12'b0};
            FMT_J: imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                            inst_i[20], inst_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I/RV64I instruction-decode stage between IF and EX.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush_i                    drop every buffered instruction on the next edge
//   in_valid_i / in_ready_o    upstream handshake (in_ready_o is registered)
//   inst_i, pc_i               raw instruction and its address
//   out_valid_o / out_ready_i  downstream handshake
//   pc_o, opcode_o, rd_o, rs1_o, rs2_o, funct3_o, funct7_o, imm_o, fmt_o,
//   rd_we_o, rs1_use_o, rs2_use_o, illegal_o   decoded bundle
// Build option: define DECODE_ILLEGAL_CHECK_EN to compute illegal_o
// (UNK format, inst[1:0]!=11, bad R-type funct7, JALR funct3!=0);
// otherwise illegal_o is constant 0.
module decode_stage
    import risc_v_pipeline_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [31:0]           inst_i,
    input  logic [XLEN-1:0]       pc_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [XLEN-1:0]       pc_o,
    output logic [6:0]            opcode_o,
    output logic [REG_ADDR_W-1:0] rd_o,
    output logic [REG_ADDR_W-1:0] rs1_o,
    output logic [REG_ADDR_W-1:0] rs2_o,
    output logic [2:0]            funct3_o,
    output logic [6:0]            funct7_o,
    output logic [XLEN-1:0]       imm_o,
    output logic [2:0]            fmt_o,
    output logic                  rd_we_o,
    output logic                  rs1_use_o,
    output logic                  rs2_use_o,
    output logic                  illegal_o
);

    // ------------------------------------------------------------------
    // Field decode
    // ------------------------------------------------------------------
    decode_bundle_t  dec_d;
    logic [XLEN-1:0] imm_d;
    logic            rd_en;
    logic            rs1_en;
    logic            rs2_en;
    logic            f3_en;

    always_comb begin
        dec_d        = '0;
        dec_d.opcode = inst_i[6:0];
        dec_d.fmt    = opcode_to_fmt(inst_i[6:0]);

        rd_en  = dec_d.fmt inside {FMT_R, FMT_I, FMT_U, FMT_J};
        rs1_en = dec_d.fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
        rs2_en = dec_d.fmt inside {FMT_R, FMT_S, FMT_B};
        f3_en  = rs1_en;

        dec_d.rd      = rd_en  ? inst_i[11:7]  : '0;
        dec_d.rs1     = rs1_en ? inst_i[19:15] : '0;
        dec_d.rs2     = rs2_en ? inst_i[24:20] : '0;
        dec_d.funct3  = f3_en  ? inst_i[14:12] : '0;
        dec_d.funct7  = (dec_d.fmt == FMT_R) ? inst_i[31:25] : '0;
        // Write-enable follows the format only; rd = x0 still reports a write.
        dec_d.rd_we   = rd_en;
        dec_d.rs1_use = rs1_en;
        dec_d.rs2_use = rs2_en;

`ifdef DECODE_ILLEGAL_CHECK_EN
        dec_d.illegal = (dec_d.fmt == FMT_UNK)
                      | (inst_i[1:0] != 2'b11)
                      | ((dec_d.fmt == FMT_R) && !(inst_i[31:25] inside {7'h00, 7'h20}))
                      | ((inst_i[6:0] == OPC_JALR) && (inst_i[14:12] != 3'b000));
`else
        dec_d.illegal = 1'b0;
`endif
    end

    decode_imm_gen #(
        .XLEN(XLEN)
    ) u_imm_gen (
        .inst_i (inst_i[31:7]),
        .fmt_i  (dec_d.fmt),
        .imm_o  (imm_d)
    );

    // ------------------------------------------------------------------
    // Output register + skid register
    // ------------------------------------------------------------------
    decode_bundle_t  out_q,      out_d;
    decode_bundle_t  skid_q,     skid_d;
    logic [XLEN-1:0] out_pc_q,   out_pc_d;
    logic [XLEN-1:0] out_imm_q,  out_imm_d;
    logic [XLEN-1:0] skid_pc_q,  skid_pc_d;
    logic [XLEN-1:0] skid_imm_q, skid_imm_d;
    logic            out_valid_q,  out_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic            accept;
    logic            out_free;

    // skid_valid_q is itself a flop, so in_ready_o has no path from out_ready_i.
    assign in_ready_o = ~skid_valid_q;
    assign accept     = in_valid_i & in_ready_o;
    assign out_free   = ~out_valid_q | out_ready_i;

    always_comb begin
        out_d        = out_q;
        out_pc_d     = out_pc_q;
        out_imm_d    = out_imm_q;
        skid_d       = skid_q;
        skid_pc_d    = skid_pc_q;
        skid_imm_d   = skid_imm_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;

        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            // A full skid blocks accept (in_ready_o=0), so the skid entry is
            // always older than anything on the input and must go first.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_pc_d     = skid_pc_q;
                out_imm_d    = skid_imm_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec_d;
                out_pc_d    = pc_i;
                out_imm_d   = imm_d;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec_d;
            skid_pc_d    = pc_i;
            skid_imm_d   = imm_d;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            out_pc_q     <= '0;
            out_imm_q    <= '0;
            skid_q       <= '0;
            skid_pc_q    <= '0;
            skid_imm_q   <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_pc_q     <= out_pc_d;
            out_imm_q    <= out_imm_d;
            skid_q       <= skid_d;
            skid_pc_q    <= skid_pc_d;
            skid_imm_q   <= skid_imm_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid_o = out_valid_q;
    assign pc_o        = out_pc_q;
    assign imm_o       = out_imm_q;
    assign opcode_o    = out_q.opcode;
    assign rd_o        = REG_ADDR_W'(out_q.rd);
    assign rs1_o       = REG_ADDR_W'(out_q.rs1);
    assign rs2_o       = REG_ADDR_W'(out_q.rs2);
    assign funct3_o    = out_q.funct3;
    assign funct7_o    = out_q.funct7;
    assign fmt_o       = out_q.fmt;
    assign rd_we_o     = out_q.rd_we;
    assign rs1_use_o   = out_q.rs1_use;
    assign rs2_use_o   = out_q.rs2_use;
    assign illegal_o   = out_q.illegal;

endmodule
